// File: rtl/watch_cal_pkg.sv
// Shared calendar types: weekday enum, display letter codes, month-length and
// weekday-text helpers used by calendar_day_tracker and day_letter_rom.
package watch_cal_pkg;

  typedef enum logic [2:0] {
    MON = 3'd0,
    TUE = 3'd1,
    WED = 3'd2,
    THU = 3'd3,
    FRI = 3'd4,
    SAT = 3'd5,
    SUN = 3'd6
  } weekday_e;

  localparam logic [3:0] C_SPACE = 4'd0;
  localparam logic [3:0] C_A     = 4'd1;
  localparam logic [3:0] C_D     = 4'd2;
  localparam logic [3:0] C_E     = 4'd3;
  localparam logic [3:0] C_F     = 4'd4;
  localparam logic [3:0] C_H     = 4'd5;
  localparam logic [3:0] C_I     = 4'd6;
  localparam logic [3:0] C_N     = 4'd7;
  localparam logic [3:0] C_O     = 4'd8;
  localparam logic [3:0] C_P     = 4'd9;
  localparam logic [3:0] C_R     = 4'd10;
  localparam logic [3:0] C_S     = 4'd11;
  localparam logic [3:0] C_T     = 4'd12;
  localparam logic [3:0] C_U     = 4'd13;
  localparam logic [3:0] C_M     = 4'd14;
  localparam logic [3:0] C_W     = 4'd15;

  // Out-of-range months report 31 so an illegal month never shortens a date.
  function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
    case (month)
      4'd2:                    return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  // Packed as {first, second, third, fourth}; the unused code 7 shows as SUN.
  function automatic logic [15:0] weekday_letters(input logic [2:0] day);
    case (day)
      MON:     return {C_M, C_O, C_N, C_SPACE};
      TUE:     return {C_T, C_U, C_E, C_SPACE};
      WED:     return {C_W, C_E, C_D, C_SPACE};
      THU:     return {C_T, C_H, C_U, C_SPACE};
      FRI:     return {C_F, C_R, C_I, C_SPACE};
      SAT:     return {C_S, C_A, C_T, C_SPACE};
      default: return {C_S, C_U, C_N, C_SPACE};
    endcase
  endfunction

endpackage

// File: rtl/day_letter_rom.sv
// Combinational weekday -> four display letter codes decoder.
module day_letter_rom
  import watch_cal_pkg::*;
(
  input  logic [2:0] day,
  output logic [3:0] first_letter,
  output logic [3:0] second_letter,
  output logic [3:0] third_letter,
  output logic [3:0] fourth_letter
);

  always_comb begin
    {first_letter, second_letter, third_letter, fourth_letter} = weekday_letters(day);
  end

endmodule

// File: rtl/calendar_day_tracker.sv
// Weekday/date/month tracker advanced by a prescaled day tick, with run/stop and
// validated load. Optional leap-year tracking under `CAL_LEAP_YEAR_EN.
module calendar_day_tracker
  import watch_cal_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned WEEK_START = 0
) (
  input  logic       clk,
  input  logic       resetTime_n,
  input  logic       day_tick,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       setValue,
  input  logic [2:0] setDay,
  input  logic [4:0] setDate,
  input  logic [3:0] setMonth,
  output logic [2:0] curDay,
  output logic [4:0] curDate,
  output logic [3:0] curMonth,
  output logic [3:0] FirstLetter,
  output logic [3:0] SecondLetter,
  output logic [3:0] ThirdLetter,
  output logic [3:0] FourthLetter,
  output logic       set_err,
  output logic       year_wrap
);

  typedef enum logic {ST_RUN, ST_STOP} run_state_e;

  localparam logic [7:0]  DIV_LAST    = 8'(TICK_DIV - 1);
  localparam logic [2:0]  DAY_RST     = 3'(WEEK_START);
  localparam logic [15:0] LETTERS_RST = weekday_letters(DAY_RST);

  run_state_e  state_q, state_d;
  logic [2:0]  day_q, day_d;
  logic [4:0]  date_q, date_d;
  logic [3:0]  month_q, month_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        set_err_q, set_err_d;
  logic        year_wrap_q, year_wrap_d;
  logic [15:0] letters_q;
  logic [3:0]  letter1_d, letter2_d, letter3_d, letter4_d;
  logic        leap;
  logic        tick_ok;
  logic        load_ok;

`ifdef CAL_LEAP_YEAR_EN
  logic [1:0] year_q, year_d;
  assign leap = (year_q == 2'd0);
`else
  assign leap = 1'b0;
`endif

  assign tick_ok = (state_q == ST_RUN) && day_tick && !stop && !setValue;
  assign load_ok = (setDay <= 3'd6) && (setMonth >= 4'd1) && (setMonth <= 4'd12) &&
                   (setDate != 5'd0) && (setDate <= month_len(setMonth, leap));

  always_comb begin
    state_d     = state_q;
    day_d       = day_q;
    date_d      = date_q;
    month_d     = month_q;
    div_cnt_d   = div_cnt_q;
    set_err_d   = 1'b0;
    year_wrap_d = 1'b0;
`ifdef CAL_LEAP_YEAR_EN
    year_d      = year_q;
`endif

    if (stop) begin
      state_d = ST_STOP;
    end else if (start_resume) begin
      state_d = ST_RUN;
    end

    // A load owns the cycle: any coincident tick is discarded with the prescale count.
    if (setValue) begin
      div_cnt_d = '0;
      if (load_ok) begin
        day_d   = setDay;
        date_d  = setDate;
        month_d = setMonth;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (tick_ok) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        day_d     = (day_q >= 3'(SUN)) ? 3'(MON) : day_q + 3'd1;
        if (date_q == month_len(month_q, leap)) begin
          date_d = 5'd1;
          if (month_q == 4'd12) begin
            month_d     = 4'd1;
            year_wrap_d = 1'b1;
`ifdef CAL_LEAP_YEAR_EN
            year_d      = year_q + 2'd1;
`endif
          end else begin
            month_d = month_q + 4'd1;
          end
        end else begin
          date_d = date_q + 5'd1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 8'd1;
      end
    end
  end

  day_letter_rom u_day_letter_rom (
    .day           (day_d),
    .first_letter  (letter1_d),
    .second_letter (letter2_d),
    .third_letter  (letter3_d),
    .fourth_letter (letter4_d)
  );

  always_ff @(posedge clk or negedge resetTime_n) begin
    if (!resetTime_n) begin
      state_q     <= ST_RUN;
      day_q       <= DAY_RST;
      date_q      <= 5'd1;
      month_q     <= 4'd1;
      div_cnt_q   <= '0;
      set_err_q   <= 1'b0;
      year_wrap_q <= 1'b0;
      letters_q   <= LETTERS_RST;
`ifdef CAL_LEAP_YEAR_EN
      year_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      day_q       <= day_d;
      date_q      <= date_d;
      month_q     <= month_d;
      div_cnt_q   <= div_cnt_d;
      set_err_q   <= set_err_d;
      year_wrap_q <= year_wrap_d;
      letters_q   <= {letter1_d, letter2_d, letter3_d, letter4_d};
`ifdef CAL_LEAP_YEAR_EN
      year_q      <= year_d;
`endif
    end
  end

  assign curDay       = day_q;
  assign curDate      = date_q;
  assign curMonth     = month_q;
  assign FirstLetter  = letters_q[15:12];
  assign SecondLetter = letters_q[11:8];
  assign ThirdLetter  = letters_q[7:4];
  assign FourthLetter = letters_q[3:0];
  assign set_err      = set_err_q;
  assign year_wrap    = year_wrap_q;

endmodule

// File: tb/tb_calendar_day_tracker.sv
// Scoreboard bench for calendar_day_tracker: TICK_DIV=1 instance (A) and TICK_DIV=3 instance (B).
module tb_calendar_day_tracker;

`ifdef CAL_LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  typedef struct {
    logic [2:0] day;
    logic [4:0] date;
    logic [3:0] month;
    logic       serr;
    logic       yw;
    logic       chkdiv;
    logic [7:0] div;
  } exp_t;

  logic clk = 1'b0;
  logic resetTime_n;

  logic       a_day_tick, a_start_resume, a_stop, a_setValue;
  logic [2:0] a_setDay;
  logic [4:0] a_setDate;
  logic [3:0] a_setMonth;
  logic [2:0] a_curDay;
  logic [4:0] a_curDate;
  logic [3:0] a_curMonth, a_l1, a_l2, a_l3, a_l4;
  logic       a_set_err, a_year_wrap;

  logic       b_day_tick, b_start_resume, b_stop, b_setValue;
  logic [2:0] b_setDay;
  logic [4:0] b_setDate;
  logic [3:0] b_setMonth;
  logic [2:0] b_curDay;
  logic [4:0] b_curDate;
  logic [3:0] b_curMonth, b_l1, b_l2, b_l3, b_l4;
  logic       b_set_err, b_year_wrap;

  exp_t qa[$];
  exp_t qb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  bit done    = 1'b0;
  bit drained = 1'b0;

  calendar_day_tracker #(.TICK_DIV(1), .WEEK_START(0)) dut_a (
    .clk(clk), .resetTime_n(resetTime_n), .day_tick(a_day_tick),
    .start_resume(a_start_resume), .stop(a_stop), .setValue(a_setValue),
    .setDay(a_setDay), .setDate(a_setDate), .setMonth(a_setMonth),
    .curDay(a_curDay), .curDate(a_curDate), .curMonth(a_curMonth),
    .FirstLetter(a_l1), .SecondLetter(a_l2), .ThirdLetter(a_l3), .FourthLetter(a_l4),
    .set_err(a_set_err), .year_wrap(a_year_wrap)
  );

  calendar_day_tracker #(.TICK_DIV(3), .WEEK_START(0)) dut_b (
    .clk(clk), .resetTime_n(resetTime_n), .day_tick(b_day_tick),
    .start_resume(b_start_resume), .stop(b_stop), .setValue(b_setValue),
    .setDay(b_setDay), .setDate(b_setDate), .setMonth(b_setMonth),
    .curDay(b_curDay), .curDate(b_curDate), .curMonth(b_curMonth),
    .FirstLetter(b_l1), .SecondLetter(b_l2), .ThirdLetter(b_l3), .FourthLetter(b_l4),
    .set_err(b_set_err), .year_wrap(b_year_wrap)
  );

  always #5 clk = ~clk;

  // Hand-written weekday text table, {first,second,third,fourth}
  function automatic logic [3:0] letter_of(input logic [2:0] d, input int unsigned idx);
    logic [15:0] t;
    case (d)
      3'd0:    t = 16'hE870;  // M O N _
      3'd1:    t = 16'hCD30;  // T U E _
      3'd2:    t = 16'hF320;  // W E D _
      3'd3:    t = 16'hC5D0;  // T H U _
      3'd4:    t = 16'h4A60;  // F R I _
      3'd5:    t = 16'hB1C0;  // S A T _
      default: t = 16'hBD70;  // S U N _
    endcase
    return 4'(t >> (12 - 4 * idx));
  endfunction

  task automatic chk(input string tag, input string name, input int unsigned act, input int unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0d required=%0d at %0t", tag, name, act, req, $time);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e,
                           input logic [2:0] d, input logic [4:0] dt, input logic [3:0] mo,
                           input logic [3:0] l1, input logic [3:0] l2, input logic [3:0] l3,
                           input logic [3:0] l4, input logic serr, input logic yw,
                           input logic [7:0] div);
    chk(tag, "curDay", d, e.day);
    chk(tag, "curDate", dt, e.date);
    chk(tag, "curMonth", mo, e.month);
    chk(tag, "letter1", l1, letter_of(e.day, 0));
    chk(tag, "letter2", l2, letter_of(e.day, 1));
    chk(tag, "letter3", l3, letter_of(e.day, 2));
    chk(tag, "letter4", l4, letter_of(e.day, 3));
    chk(tag, "set_err", serr, e.serr);
    chk(tag, "year_wrap", yw, e.yw);
    if (e.chkdiv) chk(tag, "div_cnt", div, e.div);
  endtask

  // Monitor: compares one expected record per DUT per cycle on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      check_out("A", e, a_curDay, a_curDate, a_curMonth, a_l1, a_l2, a_l3, a_l4,
                a_set_err, a_year_wrap, 8'd0);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      check_out("B", e, b_curDay, b_curDate, b_curMonth, b_l1, b_l2, b_l3, b_l4,
                b_set_err, b_year_wrap, dut_b.div_cnt_q);
    end
    if (done && !drained) begin
      chk("end", "queue_left", qa.size() + qb.size(), 0);
      drained = 1'b1;
    end
  end

  task automatic clear_inputs();
    a_day_tick = 0; a_start_resume = 0; a_stop = 0; a_setValue = 0;
    b_day_tick = 0; b_start_resume = 0; b_stop = 0; b_setValue = 0;
  endtask

  task automatic expect_a(input logic [2:0] d, input logic [4:0] dt, input logic [3:0] mo,
                          input logic serr, input logic yw);
    @(posedge clk);
    #1;
    qa.push_back('{day: d, date: dt, month: mo, serr: serr, yw: yw, chkdiv: 1'b0, div: 8'd0});
    clear_inputs();
  endtask

  task automatic expect_b(input logic [2:0] d, input logic [4:0] dt, input logic [3:0] mo,
                          input logic [7:0] div);
    @(posedge clk);
    #1;
    qb.push_back('{day: d, date: dt, month: mo, serr: 1'b0, yw: 1'b0, chkdiv: 1'b1, div: div});
    clear_inputs();
  endtask

  task automatic load_a(input logic [2:0] sd, input logic [4:0] sdt, input logic [3:0] smo);
    a_setValue = 1; a_setDay = sd; a_setDate = sdt; a_setMonth = smo;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 resetTime_n = 0;
    @(negedge clk);
    #1 resetTime_n = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    a_setDay = 0; a_setDate = 0; a_setMonth = 0;
    b_setDay = 0; b_setDate = 0; b_setMonth = 0;
    resetTime_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetTime_n = 1;

    expect_a(0, 1, 1, 0, 0);                      // reset state, MON letters
    for (int i = 1; i <= 7; i++) begin            // full week back to MON
      a_day_tick = 1;
      expect_a(3'(i % 7), 5'(1 + i), 4'd1, 0, 0);
    end

    load_a(3, 31, 12);   expect_a(3, 31, 12, 0, 0);
    a_day_tick = 1;      expect_a(4, 1, 1, 0, 1);  // year wrap, FRI
    expect_a(4, 1, 1, 0, 0);
    load_a(1, 31, 4);    expect_a(4, 1, 1, 1, 0);  // 31 April rejected
    load_a(2, 30, 4);    expect_a(2, 30, 4, 0, 0);

    a_stop = 1;          expect_a(2, 30, 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      a_day_tick = 1;    expect_a(2, 30, 4, 0, 0);
    end
    a_start_resume = 1;  expect_a(2, 30, 4, 0, 0);
    a_day_tick = 1;      expect_a(3, 1, 5, 0, 0);

    a_stop = 1; a_start_resume = 1; expect_a(3, 1, 5, 0, 0);
    a_day_tick = 1;      expect_a(3, 1, 5, 0, 0);  // still stopped
    a_start_resume = 1;  expect_a(3, 1, 5, 0, 0);
    a_day_tick = 1;      expect_a(4, 2, 5, 0, 0);
    a_day_tick = 1; a_stop = 1; expect_a(4, 2, 5, 0, 0);  // stop blocks same-cycle tick
    a_start_resume = 1;  expect_a(4, 2, 5, 0, 0);
    a_day_tick = 1;      expect_a(5, 3, 5, 0, 0);

    a_stop = 1;          expect_a(5, 3, 5, 0, 0);
    load_a(6, 15, 7);    expect_a(6, 15, 7, 0, 0); // load while stopped
    a_day_tick = 1;      expect_a(6, 15, 7, 0, 0);
    a_start_resume = 1;  expect_a(6, 15, 7, 0, 0);
    a_day_tick = 1;      expect_a(0, 16, 7, 0, 0);

    load_a(7, 1, 1);     expect_a(0, 16, 7, 1, 0);
    load_a(1, 1, 13);    expect_a(0, 16, 7, 1, 0);
    load_a(1, 1, 0);     expect_a(0, 16, 7, 1, 0);
    load_a(1, 0, 1);     expect_a(0, 16, 7, 1, 0);
    load_a(1, 31, 11);   expect_a(0, 16, 7, 1, 0);
    load_a(6, 31, 1);    expect_a(6, 31, 1, 0, 0);

    pulse_reset();
    expect_a(0, 1, 1, 0, 0);

    load_a(0, 28, 2);    expect_a(0, 28, 2, 0, 0);
    a_day_tick = 1;
    if (LEAP) expect_a(1, 29, 2, 0, 0); else expect_a(1, 1, 3, 0, 0);
    a_day_tick = 1;
    if (LEAP) expect_a(2, 1, 3, 0, 0); else expect_a(2, 2, 3, 0, 0);

    for (int k = 1; k <= 4; k++) begin
      load_a(0, 31, 12); expect_a(0, 31, 12, 0, 0);
      a_day_tick = 1;    expect_a(1, 1, 1, 0, 1);
      load_a(0, 28, 2);  expect_a(0, 28, 2, 0, 0);
      a_day_tick = 1;
      if (LEAP && k == 4) expect_a(1, 29, 2, 0, 0); else expect_a(1, 1, 3, 0, 0);
    end
    load_a(3, 29, 2);
    if (LEAP) expect_a(3, 29, 2, 0, 0); else expect_a(1, 1, 3, 1, 0);
    load_a(0, 31, 12);   expect_a(0, 31, 12, 0, 0);
    a_day_tick = 1;      expect_a(1, 1, 1, 0, 1);
    load_a(3, 29, 2);    expect_a(1, 1, 1, 1, 0);  // non-leap year in either build

    expect_b(0, 1, 1, 0);
    b_day_tick = 1; expect_b(0, 1, 1, 1);
    b_day_tick = 1; expect_b(0, 1, 1, 2);
    b_day_tick = 1; expect_b(1, 2, 1, 0);
    b_day_tick = 1; expect_b(1, 2, 1, 1);
    b_day_tick = 1; expect_b(1, 2, 1, 2);
    b_setValue = 1; b_setDay = 5; b_setDate = 10; b_setMonth = 6; b_day_tick = 1;
    expect_b(5, 10, 6, 0);
    b_day_tick = 1; expect_b(5, 10, 6, 1);
    b_day_tick = 1; expect_b(5, 10, 6, 2);
    b_day_tick = 1; expect_b(6, 11, 6, 0);
    b_day_tick = 1; expect_b(6, 11, 6, 1);
    pulse_reset();
    expect_b(0, 1, 1, 0);                          // pending count cleared
    b_day_tick = 1; expect_b(0, 1, 1, 1);

    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calendar_day_tracker.md
# calendar_day_tracker

Parametrised successor to the watch controller's weekday display block. It tracks weekday, date, month and (optionally) year-mod-4 from a once-per-day tick, and supports run/stop control and a validated parallel load. It emits four registered 4-bit letter codes for the weekday text field. It sits between the time-of-day counter (source of `day_tick`) and the character display driver.

## Interface
- `TICK_DIV`, default 1: number of accepted `day_tick` pulses per calendar advance (range 1..255; values above 1 are for bench/demo speed-down).
- `WEEK_START`, default 0: weekday loaded at reset (0=MON … 6=SUN).
- `clk`  in  1  system clock; all state on rising edge.
- `resetTime_n`  in  1  reset, asynchronous assert, active-low.
- `day_tick`  in  1  single-cycle pulse, one per elapsed day.
- `start_resume`  in  1  level-sampled pulse; enables advancing.
- `stop`  in  1  level-sampled pulse; disables advancing.
- `setValue`  in  1  single-cycle load strobe.
- `setDay`  in  3  weekday to load (0..6).
- `setDate`  in  5  date to load (1..31).
- `setMonth`  in  4  month to load (1..12).
- `curDay`  out  3  current weekday.
- `curDate`  out  5  current date.
- `curMonth`  out  4  current month.
- `FirstLetter`, `SecondLetter`, `ThirdLetter`, `FourthLetter`  out  4 each  weekday text codes.
- `set_err`  out  1  one-cycle pulse on a rejected load.
- `year_wrap`  out  1  one-cycle pulse on the Dec 31 → Jan 1 advance.

## Operation
- Letter alphabet: SPACE=0, A=1, D=2, E=3, F=4, H=5, I=6, N=7, O=8, P=9, R=10, S=11, T=12, U=13, M=14, W=15.
- Weekday text: MON␣, TUE␣, WED␣, THU␣, FRI␣, SAT␣, SUN␣. Fourth letter is always SPACE. Code 7 is never produced; if reached, it displays as SUN and advances to MON.
- Run FSM has two states:
  - RUN → STOP on `stop`.
  - STOP → RUN on `start_resume`.
  - If both are high in the same cycle, `stop` wins.
  - After reset the FSM is in RUN.
- Prescaler `div_cnt` (8 bit) counts accepted ticks; an advance fires when `div_cnt` reaches TICK_DIV-1, then clears. A tick is accepted only in RUN with `setValue` low.
- Advance:
  - weekday: +1 mod 7.
  - date: +1. If date equals the month length, date becomes 1 and month increments; month 12 wraps to 1 and `year_wrap` pulses.
- Month lengths:
  - 31: months 1, 3, 5, 7, 8, 10, 12.
  - 30: months 4, 6, 9, 11.
  - Feb: 28, or 29 per Configuration.
- Load:
  - `setValue` takes priority over the tick in the same cycle. A tick in that cycle is dropped and `div_cnt` clears.
  - Valid when setDay≤6, 1≤setMonth≤12 and 1≤setDate≤month length (Feb length uses the current leap state).
  - Invalid: no state change, `set_err`=1 for one cycle.
  - A load works in either FSM state and does not change the FSM state.

## Timing
- Reset values:
  - curDay=WEEK_START, curDate=1, curMonth=1, year=0, div_cnt=0, FSM=RUN.
  - Letters decode WEEK_START (MON␣ at default).
  - set_err=0, year_wrap=0.
- curDay/curDate/curMonth update on the same edge that samples the tick or load.
- Letters are decoded from next-state and registered on that same edge, so they are never a cycle stale.
- `set_err` and `year_wrap` are registered and high exactly one cycle, on the edge after the triggering input.
- Reset mid-operation clears everything asynchronously, including a pending prescale count.
- A `stop` in cycle N blocks a tick in cycle N.

## Configuration
- `CAL_LEAP_YEAR_EN` defined:
  - 2-bit `year` counter increments on each `year_wrap`.
  - Feb has 29 days when year==0, else 28.
  - Load validation uses the same rule.
- Macro undefined: no year register, Feb is always 28, and setDate=29 with setMonth=2 is rejected.

## Structure
- Package `watch_cal_pkg` holds the weekday enum (MON..SUN), letter-code localparams (C_SPACE..C_W) and a month-length function.
- Sub-module `day_letter_rom` is a combinational weekday → four letter codes decoder, instantiated once on the next-state weekday.

## Test plan
- Reset with WEEK_START=0 → curDay=0, date 1/1, letters 14,8,7,0. Seven ticks then return to MON, passing through TUE=12,13,3,0.
- Load day=3, date=31, month=12, then one tick → curDay=4, date 1, month 1, `year_wrap` pulse, letters FRI␣=4,10,6,0.
- Load date=31, month=4 → `set_err` pulse and all outputs unchanged. Load date=30, month=4 is accepted.
- `stop`, three ticks, then `start_resume` and one tick → a single advance. `stop`+`start_resume` together leave the FSM in STOP.
- TICK_DIV=3: five ticks → one advance, with `div_cnt`=2. `setValue` together with a tick → load applied, tick dropped, `div_cnt`=0.
- Leap year with CAL_LEAP_YEAR_EN: from reset (year 0), load 28/2 and tick → 29/2, tick → 1/3. After four year wraps, 28/2 plus a tick → 29/2. Without the macro, 28/2 plus a tick → 1/3.
